// File: rtl/otter_iobus_timer.sv
// otter_iobus_timer: memory-mapped interval timer and interrupt source on the OTTER IOBUS
module otter_iobus_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          PRESCALE_W = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        HIT,
  output logic        INTR
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                state_q;
  logic                  auto_q, irq_en_q, pending_q, overrun_q, intr_q;
  logic [PRESCALE_W-1:0] prescale_q, presc_q;
  logic [31:0]           reload_q, count_q;
  logic [2:0]            idx;
  logic                  wr, we_ctrl, we_pre, we_rel, we_cnt, we_stat;
  logic                  tick, expire, clr_pend, clr_ovr, pending_d, overrun_d, irq_en_d;
  logic                  unused_addr;
  assign unused_addr = ^IOBUS_ADDR[1:0];
  assign HIT      = IOBUS_ADDR[31:5] == BASE_ADDR[31:5];
  assign idx      = IOBUS_ADDR[4:2];
  assign wr       = IOBUS_WR & HIT;
  assign we_ctrl  = wr && idx == 3'd0;
  assign we_pre   = wr && idx == 3'd1;
  assign we_rel   = wr && idx == 3'd2;
  assign we_cnt   = wr && idx == 3'd3;
  assign we_stat  = wr && idx == 3'd4;
  assign clr_pend = we_stat & IOBUS_OUT[0];
  assign clr_ovr  = we_stat & IOBUS_OUT[1];
  // a COUNT write in the same cycle swallows the tick entirely
  assign tick      = state_q == RUN && presc_q == prescale_q && !we_cnt;
  assign expire    = tick && count_q == 32'd0;
  assign pending_d = expire | (pending_q & ~clr_pend);
  assign overrun_d = (expire & pending_q & ~clr_pend) | (overrun_q & ~clr_ovr);
  assign irq_en_d  = we_ctrl ? IOBUS_OUT[2] : irq_en_q;
  assign INTR      = intr_q;
  // zero-latency read mux; unmapped indexes and misses read as zero
  always_comb begin
    IOBUS_IN = !HIT        ? 32'd0 :
               idx == 3'd0 ? {29'd0, irq_en_q, auto_q, state_q == RUN} :
               idx == 3'd1 ? 32'(prescale_q) :
               idx == 3'd2 ? reload_q :
               idx == 3'd3 ? count_q :
               idx == 3'd4 ? {30'd0, overrun_q, pending_q} : 32'd0;
  end
  // run/idle control, register file, prescaler and countdown
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      intr_q     <= 1'b0;
      prescale_q <= '0;
      presc_q    <= '0;
      reload_q   <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      intr_q    <= pending_d & irq_en_d;
      irq_en_q  <= irq_en_d;
      if (we_ctrl) auto_q <= IOBUS_OUT[1];
      if (we_pre) prescale_q <= IOBUS_OUT[PRESCALE_W-1:0];
      if (we_rel) reload_q <= IOBUS_OUT;
      if (we_cnt) count_q <= IOBUS_OUT;
      else if (tick) count_q <= expire ? (auto_q ? reload_q : count_q) : count_q - 32'd1;
      if (we_cnt || state_q == IDLE || (we_ctrl && !IOBUS_OUT[0])) presc_q <= '0;
      else presc_q <= tick ? '0 : presc_q + 1'b1;
      if (we_ctrl) state_q <= IOBUS_OUT[0] ? RUN : IDLE;
      else if (expire && !auto_q) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_otter_iobus_timer.sv
// tb_otter_iobus_timer: directed and randomized checks of the IOBUS timer
module tb_otter_iobus_timer;
  localparam logic [31:0] B = 32'h1100_0100;
  localparam logic [31:0] CTRL = B, PRE = B + 4, REL = B + 8, CNT = B + 12, STAT = B + 16;
  logic        clk = 1'b0, rst = 1'b1, we = 1'b0, hit, intr;
  logic [31:0] addr = 32'd0, dout = 32'd0, din;
  int          n_chk = 0, n_fail = 0;
  otter_iobus_timer dut (
    .CLK(clk), .RST(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(dout), .IOBUS_WR(we),
    .IOBUS_IN(din), .HIT(hit), .INTR(intr)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    dout = d;
    we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1 check(tag, din, exp);
  endtask
  task automatic chk_hit(input logic [31:0] a, input logic exp);
    addr = a;
    #1 check("hit", 32'(hit), 32'(exp));
  endtask
  int n, p, r, au, ir, first, per, k;
  logic pend, ovr, ex, do_w;
  logic [1:0] clr;
  logic [31:0] c;
  initial begin
    repeat (2) begin
      @(negedge clk);
      addr = B + 32'($urandom_range(0, 31));
      dout = $urandom;
      we = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b0;
    we = 1'b0;
    for (int i = 0; i < 8; i++) chk_rd("rst_read", B + 32'(4 * i), 32'd0);
    check("rst_intr", 32'(intr), 32'd0);
    chk_hit(32'h1100_00FF, 1'b0);
    chk_hit(32'h1100_0100, 1'b1);
    chk_hit(32'h1100_011F, 1'b1);
    chk_hit(32'h1100_0120, 1'b0);
    // one-shot: expiry on the 8th edge after the enabling write
    wr(CNT, 3);
    wr(PRE, 1);
    wr(CTRL, 5);
    cyc(7);
    chk_rd("os_pre_stat", STAT, 0);
    check("os_pre_intr", 32'(intr), 0);
    cyc(1);
    chk_rd("os_stat", STAT, 1);
    check("os_intr", 32'(intr), 1);
    chk_rd("os_ctrl", CTRL, 4);
    chk_rd("os_cnt", CNT, 0);
    wr(STAT, 1);
    check("os_intr_clr", 32'(intr), 0);
    // auto-reload every 3 cycles, with one skipped clear
    wr(REL, 2);
    wr(CNT, 2);
    wr(PRE, 0);
    wr(CTRL, 7);
    cyc(3);
    for (int i = 0; i < 3; i++) begin
      chk_rd("ar_stat", STAT, 1);
      wr(STAT, 1);
      cyc(2);
    end
    chk_rd("ar_stat", STAT, 1);
    cyc(3);
    chk_rd("ar_ovr", STAT, 3);
    wr(CTRL, 0);
    wr(STAT, 3);
    // clear issued on the exact expiry edge while already pending
    wr(CNT, 2);
    wr(CTRL, 7);
    cyc(5);
    wr(STAT, 1);
    chk_rd("race_stat", STAT, 1);
    check("race_intr", 32'(intr), 1);
    wr(CTRL, 0);
    wr(STAT, 3);
    // COUNT write on a tick edge
    wr(PRE, 2);
    wr(CNT, 100);
    wr(CTRL, 1);
    cyc(5);
    wr(CNT, 32'h10);
    chk_rd("cw_now", CNT, 32'h10);
    cyc(2);
    chk_rd("cw_hold", CNT, 32'h10);
    cyc(1);
    chk_rd("cw_dec", CNT, 32'h0F);
    wr(CTRL, 0);
    // randomized scenarios against an arithmetic model of tick/expiry times
    for (int s = 0; s < 12; s++) begin
      n = $urandom_range(0, 5);
      p = $urandom_range(0, 3);
      r = $urandom_range(0, 4);
      au = $urandom_range(0, 1);
      ir = $urandom_range(0, 1);
      pend = 1'b0;
      ovr = 1'b0;
      wr(STAT, 3);
      wr(PRE, 32'(p));
      wr(REL, 32'(r));
      wr(CNT, 32'(n));
      wr(CTRL, 32'(4 * ir + 2 * au + 1));
      first = (n + 1) * (p + 1);
      per = (r + 1) * (p + 1);
      for (int t = 1; t <= 36; t++) begin
        do_w = $urandom_range(0, 3) == 0;
        clr = do_w ? 2'($urandom_range(0, 3)) : 2'd0;
        if (do_w) wr(STAT, 32'(clr));
        else cyc(1);
        ex = au != 0 ? (t >= first && (t - first) % per == 0) : (t == first);
        k = t / (p + 1);
        c = k <= n ? 32'(n - k) : (au != 0 ? 32'(r - (k - n - 1) % (r + 1)) : 32'd0);
        ovr = (ex & pend & ~clr[0]) | (ovr & ~clr[1]);
        pend = ex | (pend & ~clr[0]);
        chk_rd("rnd_stat", STAT, {30'd0, ovr, pend});
        chk_rd("rnd_cnt", CNT, c);
        chk_rd("rnd_ctrl", CTRL, 32'(4 * ir + 2 * au + ((au != 0 || t < first) ? 1 : 0)));
        check("rnd_intr", 32'(intr), 32'(pend & (ir != 0)));
      end
      wr(CTRL, 0);
      wr(STAT, 3);
      chk_rd("rnd_end", STAT, 0);
    end
    // decode: unmapped index and out-of-window writes change nothing
    wr(PRE, 7);
    wr(REL, 9);
    wr(CNT, 5);
    wr(B + 24, 32'hFFFF_FFFF);
    wr(32'h1100_0200, 32'hFFFF_FFFF);
    chk_rd("dec_ctrl", CTRL, 0);
    chk_rd("dec_pre", PRE, 7);
    chk_rd("dec_rel", REL, 9);
    chk_rd("dec_cnt", CNT, 5);
    chk_rd("dec_stat", STAT, 0);
    chk_rd("dec_unmap", B + 24, 0);
    chk_hit(B + 24, 1'b1);
    chk_rd("dec_miss", 32'h1100_0200, 0);
    chk_hit(32'h1100_0200, 1'b0);
    chk_rd("dec_lowbits", B + 15, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
